// File: rtl/mul_pkg.sv
// Shared types for the M-extension multiply issue path.
// Holds funct3 encodings, FSM states and default core latency.
package mul_pkg;

  localparam int MUL_LATENCY_DEF = 8;

  typedef enum logic [1:0] {
    F3_MUL    = 2'b00,
    F3_MULH   = 2'b01,
    F3_MULHSU = 2'b10,
    F3_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } mul_state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional 64-bit negate of an unsigned product plus half-select.
// Ports: prod in, neg (negate), hi (upper half), res out.
module mul_sign_fix (
  input  logic [63:0] prod,
  input  logic        neg,
  input  logic        hi,
  output logic [31:0] res
);

  logic [63:0] p;

  assign p   = neg ? -prod : prod;
  assign res = hi ? p[63:32] : p[31:0];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiply issue control: sign strip, settle window, sign restore.
// Ports: in_* request handshake, core_* multiplier, out_* result.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic [31:0] core_op1,
  output logic [31:0] core_op2,
  input  logic [63:0] core_answer,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam int CW = $clog2(MUL_LATENCY);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(MUL_LATENCY - 1);

  mul_state_e    state;
  mul_state_e    nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    f3_q;
  logic          neg_q;
  logic          s1;
  logic          s2;
  logic          acc;
  logic          zero;
  logic          hi_sel;
  logic [31:0]   m1;
  logic [31:0]   m2;
  logic [31:0]   fix;

  assign in_ready = (state == IDLE) && !flush;
  assign acc      = in_valid && in_ready;

  assign s1 = rs1[31] &&
    (funct3 == F3_MULH || funct3 == F3_MULHSU);
  assign s2 = rs2[31] && (funct3 == F3_MULH);

  // 0x8000_0000 negates to itself, which is the
  // correct unsigned magnitude.
  assign m1   = s1 ? -rs1 : rs1;
  assign m2   = s2 ? -rs2 : rs2;
  assign zero = (m1 == '0) || (m2 == '0);

  assign hi_sel = (f3_q != F3_MUL);

  mul_sign_fix u_fix (
    .prod (core_answer),
    .neg  (neg_q),
    .hi   (hi_sel),
    .res  (fix)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (acc) nxt = zero ? DONE : ISSUE;
      ISSUE:   if (cnt == CNT_LAST) nxt = CAPTURE;
      CAPTURE: nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      core_op1  <= '0;
      core_op2  <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= (nxt == DONE);
      if (flush) begin
        cnt      <= '0;
        core_op1 <= '0;
        core_op2 <= '0;
      end else begin
        unique case (state)
          IDLE: if (acc) begin
            f3_q  <= funct3;
            neg_q <= s1 ^ s2;
            cnt   <= '0;
            if (zero) begin
              result <= '0;
            end else begin
              core_op1 <= m1;
              core_op2 <= m2;
            end
          end
          ISSUE: cnt <= cnt + 1'b1;
          // Operands stay on the core through this
          // cycle so the sampled answer is settled.
          CAPTURE: begin
            result   <= fix;
            core_op1 <= '0;
            core_op2 <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
